// File: rtl/control_unit.sv
// Control unit for a single-cycle RV32I-subset core.
//
// Holds the program counter and a sticky illegal/halt flag; everything else is
// a combinational decode of the instruction word fetched at pc.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset (0 = in reset)
//   instr      instruction word at pc
//   alu_zero   ALU result == 0 for the current instruction (branch condition)
//   pc         current program counter / instruction-memory address
//   pc_plus4   pc + 4, link value for JAL
//   rs1/rs2/rd register indices taken straight from the instruction fields
//   imm        sign-extended immediate selected by opcode
//   alu_src    0 = rs2 data, 1 = imm as ALU operand B
//   alu_ctrl   ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLT=5 SLL=6 SRL=7 SRA=8
//   reg_write  register-file write enable
//   mem_read   data-memory read enable
//   mem_write  data-memory write enable
//   wb_sel     00 ALU, 01 memory, 10 pc_plus4, 11 imm
//   illegal    sticky illegal-instruction / halted flag
module control_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned XLEN     = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] instr,
  input  logic            alu_zero,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic            alu_src,
  output logic [3:0]      alu_ctrl,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic [1:0]      wb_sel,
  output logic            illegal
);

  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIAlu   = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpLui    = 7'b0110111;

  localparam logic [3:0] AluAdd = 4'd0;
  localparam logic [3:0] AluSub = 4'd1;
  localparam logic [3:0] AluAnd = 4'd2;
  localparam logic [3:0] AluOr  = 4'd3;
  localparam logic [3:0] AluXor = 4'd4;
  localparam logic [3:0] AluSlt = 4'd5;
  localparam logic [3:0] AluSll = 4'd6;
  localparam logic [3:0] AluSrl = 4'd7;
  localparam logic [3:0] AluSra = 4'd8;

  localparam logic [1:0] WbAlu = 2'b00;
  localparam logic [1:0] WbMem = 2'b01;
  localparam logic [1:0] WbPc4 = 2'b10;
  localparam logic [1:0] WbImm = 2'b11;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  logic [XLEN-1:0] pc_q, pc_d;
  logic            illegal_q, illegal_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_sh;
  logic [XLEN-1:0] imm_dec, next_pc, pc_inc;
  logic [3:0]      alu_dec;
  logic [1:0]      wb_dec;
  logic            src_dec, rw_dec, mr_dec, mw_dec;
  logic            dec_illegal, is_beq, is_bne, is_jal, take_target;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  assign imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s  = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j  = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21],
                   1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  // Shift-immediate forms hand the ALU a clean shamt rather than the raw I field.
  assign imm_sh = {{(XLEN-5){1'b0}}, instr[24:20]};

  always_comb begin
    alu_dec     = AluAdd;
    src_dec     = 1'b0;
    wb_dec      = WbAlu;
    rw_dec      = 1'b0;
    mr_dec      = 1'b0;
    mw_dec      = 1'b0;
    imm_dec     = '0;
    dec_illegal = 1'b0;
    is_beq      = 1'b0;
    is_bne      = 1'b0;
    is_jal      = 1'b0;

    case (opcode)
      OpRType: begin
        rw_dec = 1'b1;
        if (funct7 == F7Base) begin
          case (funct3)
            3'b000:  alu_dec = AluAdd;
            3'b001:  alu_dec = AluSll;
            3'b010:  alu_dec = AluSlt;
            3'b100:  alu_dec = AluXor;
            3'b101:  alu_dec = AluSrl;
            3'b110:  alu_dec = AluOr;
            3'b111:  alu_dec = AluAnd;
            default: dec_illegal = 1'b1;
          endcase
        end else if (funct7 == F7Alt && funct3 == 3'b000) begin
          alu_dec = AluSub;
        end else if (funct7 == F7Alt && funct3 == 3'b101) begin
          alu_dec = AluSra;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OpIAlu: begin
        rw_dec  = 1'b1;
        src_dec = 1'b1;
        imm_dec = imm_i;
        case (funct3)
          3'b000: alu_dec = AluAdd;
          3'b010: alu_dec = AluSlt;
          3'b100: alu_dec = AluXor;
          3'b110: alu_dec = AluOr;
          3'b111: alu_dec = AluAnd;
          3'b001: begin
            alu_dec     = AluSll;
            imm_dec     = imm_sh;
            dec_illegal = (funct7 != F7Base);
          end
          3'b101: begin
            alu_dec     = (funct7 == F7Alt) ? AluSra : AluSrl;
            imm_dec     = imm_sh;
            dec_illegal = (funct7 != F7Base) && (funct7 != F7Alt);
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      OpLoad: begin
        src_dec     = 1'b1;
        imm_dec     = imm_i;
        mr_dec      = 1'b1;
        rw_dec      = 1'b1;
        wb_dec      = WbMem;
        dec_illegal = (funct3 != 3'b010);
      end
      OpStore: begin
        src_dec     = 1'b1;
        imm_dec     = imm_s;
        mw_dec      = 1'b1;
        dec_illegal = (funct3 != 3'b010);
      end
      OpBranch: begin
        alu_dec     = AluSub;
        imm_dec     = imm_b;
        is_beq      = (funct3 == 3'b000);
        is_bne      = (funct3 == 3'b001);
        dec_illegal = !(is_beq || is_bne);
      end
      OpJal: begin
        rw_dec  = 1'b1;
        wb_dec  = WbPc4;
        imm_dec = imm_j;
        is_jal  = 1'b1;
      end
      OpLui: begin
        rw_dec  = 1'b1;
        wb_dec  = WbImm;
        imm_dec = imm_u;
      end
      default: dec_illegal = 1'b1;
    endcase

    // An illegal word drives nothing: all enables off, fields back to defaults.
    if (dec_illegal) begin
      alu_dec = AluAdd;
      src_dec = 1'b0;
      wb_dec  = WbAlu;
      rw_dec  = 1'b0;
      mr_dec  = 1'b0;
      mw_dec  = 1'b0;
      imm_dec = '0;
      is_beq  = 1'b0;
      is_bne  = 1'b0;
      is_jal  = 1'b0;
    end
  end

  assign pc_inc      = pc_q + 32'd4;
  assign take_target = (is_beq & alu_zero) | (is_bne & ~alu_zero) | is_jal;

  always_comb begin
    next_pc   = take_target ? (pc_q + imm_dec) : pc_inc;
    // Halted, or about to halt: the pc stays on the offending instruction.
    pc_d      = (illegal_q || dec_illegal) ? pc_q : next_pc;
    illegal_d = illegal_q | dec_illegal;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      illegal_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      illegal_q <= illegal_d;
    end
  end

  assign pc        = pc_q;
  assign pc_plus4  = pc_inc;
  assign rs1       = instr[19:15];
  assign rs2       = instr[24:20];
  assign rd        = instr[11:7];
  assign imm       = imm_dec;
  assign alu_src   = src_dec;
  assign alu_ctrl  = alu_dec;
  assign wb_sel    = wb_dec;
  assign reg_write = rw_dec & ~illegal_q;
  assign mem_read  = mr_dec & ~illegal_q;
  assign mem_write = mw_dec & ~illegal_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed steps followed by random
// instruction words, compared against an instruction-level reference model.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        alu_zero;
  logic [31:0] pc, pc_plus4, imm;
  logic [4:0]  rs1, rs2, rd;
  logic        alu_src, reg_write, mem_read, mem_write, illegal;
  logic [3:0]  alu_ctrl;
  logic [1:0]  wb_sel;

  int tests = 0;
  int fails = 0;

  control_unit #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .instr     (instr),
    .alu_zero  (alu_zero),
    .pc        (pc),
    .pc_plus4  (pc_plus4),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .imm       (imm),
    .alu_src   (alu_src),
    .alu_ctrl  (alu_ctrl),
    .reg_write (reg_write),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .wb_sel    (wb_sel),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  // Expected decode of one instruction word. kind: 0 sequential, 1 BEQ, 2 BNE, 3 JAL.
  typedef struct packed {
    logic        legal;
    logic [3:0]  alu;
    logic        src;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [1:0]  wb;
    logic [31:0] imm;
    logic [1:0]  kind;
  } exp_t;

  logic [31:0] m_pc;
  bit          m_halt;
  exp_t        cur_e;
  logic        cur_z;
  logic [31:0] halt_seq [0:3];

  function automatic int sext(input int v, input int bits);
    if (v >= (1 << (bits - 1))) return v - (1 << bits);
    return v;
  endfunction

  function automatic int alu_of(input int f3, input bit alt);
    case (f3)
      0:       return alt ? 1 : 0;
      1:       return 6;
      2:       return 5;
      4:       return 4;
      5:       return alt ? 8 : 7;
      6:       return 3;
      7:       return 2;
      default: return 0;
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    int   op, f3, f7, v;
    e  = '0;
    op = int'(w[6:0]);
    f3 = int'(w[14:12]);
    f7 = int'(w[31:25]);
    case (op)
      51: begin
        e.legal = (f3 != 3) && (f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)));
        e.alu   = 4'(alu_of(f3, f7 == 32));
        e.rw    = 1'b1;
      end
      19: begin
        if (f3 == 1)      e.legal = (f7 == 0);
        else if (f3 == 5) e.legal = (f7 == 0 || f7 == 32);
        else              e.legal = (f3 != 3);
        e.alu = 4'(alu_of(f3, f3 == 5 && f7 == 32));
        e.src = 1'b1;
        e.rw  = 1'b1;
        if (f3 == 1 || f3 == 5) e.imm = 32'(int'(w[24:20]));
        else                    e.imm = 32'(sext(int'(w[31:20]), 12));
      end
      3: begin
        e.legal = (f3 == 2);
        e.src   = 1'b1;
        e.mr    = 1'b1;
        e.rw    = 1'b1;
        e.wb    = 2'd1;
        e.imm   = 32'(sext(int'(w[31:20]), 12));
      end
      35: begin
        e.legal = (f3 == 2);
        e.src   = 1'b1;
        e.mw    = 1'b1;
        v       = int'(w[31:25]) * 32 + int'(w[11:7]);
        e.imm   = 32'(sext(v, 12));
      end
      99: begin
        e.legal = (f3 <= 1);
        e.alu   = 4'd1;
        e.kind  = (f3 == 0) ? 2'd1 : 2'd2;
        v = int'(w[31]) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        e.imm   = 32'(sext(v, 13));
      end
      111: begin
        e.legal = 1'b1;
        e.rw    = 1'b1;
        e.wb    = 2'd2;
        e.kind  = 2'd3;
        v = int'(w[31]) * (1 << 20) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
            + int'(w[30:21]) * 2;
        e.imm   = 32'(sext(v, 21));
      end
      55: begin
        e.legal = 1'b1;
        e.rw    = 1'b1;
        e.wb    = 2'd3;
        e.imm   = 32'(w[31:12]) * 32'd4096;
      end
      default: e.legal = 1'b0;
    endcase
    if (!e.legal) e = '0;
    return e;
  endfunction

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input int off);
    logic [12:0] o;
    o = 13'(off);
    return {o[12], o[10:5], 5'd2, 5'd1, f3, o[4:1], o[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [4:0] rdx, input int off);
    logic [20:0] o;
    o = 21'(off);
    return {o[20], o[10:1], o[11], o[19:12], rdx, 7'h6F};
  endfunction

  function automatic logic [6:0] pick_f7();
    case ($urandom_range(0, 3))
      0:       return 7'($urandom);
      1:       return 7'h20;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int          sel;
    w   = $urandom;
    sel = $urandom_range(0, 15);
    if (sel <= 3) begin
      w[6:0] = 7'h33; w[31:25] = pick_f7();
    end else if (sel <= 6) begin
      w[6:0] = 7'h13; w[31:25] = pick_f7();
    end else if (sel <= 8) begin
      w[6:0] = (sel == 7) ? 7'h03 : 7'h23;
      if ($urandom_range(0, 5) != 0) w[14:12] = 3'd2;
    end else if (sel <= 10) begin
      w[6:0] = 7'h63;
      if ($urandom_range(0, 5) != 0) w[14:12] = 3'($urandom_range(0, 1));
    end else if (sel <= 12) begin
      w[6:0] = 7'h6F;
    end else if (sel == 13) begin
      w[6:0] = 7'h37;
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Present an instruction and check the zero-latency decode.
  task automatic apply(input logic [31:0] w, input logic z);
    instr    = w;
    alu_zero = z;
    cur_e    = model(w);
    cur_z    = z;
    #1;
    chk("rs1", 32'(rs1), (w >> 15) & 32'h1F);
    chk("rs2", 32'(rs2), (w >> 20) & 32'h1F);
    chk("rd", 32'(rd), (w >> 7) & 32'h1F);
    chk("alu_ctrl", 32'(alu_ctrl), 32'(cur_e.alu));
    chk("alu_src", 32'(alu_src), 32'(cur_e.src));
    chk("wb_sel", 32'(wb_sel), 32'(cur_e.wb));
    chk("reg_write", 32'(reg_write), 32'(cur_e.rw && !m_halt));
    chk("mem_read", 32'(mem_read), 32'(cur_e.mr && !m_halt));
    chk("mem_write", 32'(mem_write), 32'(cur_e.mw && !m_halt));
    if (cur_e.legal) chk("imm", imm, cur_e.imm);
    chk("pc", pc, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("illegal", 32'(illegal), 32'(m_halt));
  endtask

  // One clock edge, then check the architectural state against the model.
  task automatic tick();
    bit jump;
    @(posedge clk);
    #1;
    if (!m_halt) begin
      if (!cur_e.legal) begin
        m_halt = 1'b1;
      end else begin
        jump = (cur_e.kind == 2'd3) || (cur_e.kind == 2'd1 && cur_z) ||
               (cur_e.kind == 2'd2 && !cur_z);
        m_pc = jump ? m_pc + cur_e.imm : m_pc + 32'd4;
      end
    end
    chk("pc_after_edge", pc, m_pc);
    chk("illegal_after_edge", 32'(illegal), 32'(m_halt));
  endtask

  // Asserted between edges and held across one edge: state must clear at once.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    m_pc   = 32'h0;
    m_halt = 1'b0;
    chk("reset_pc_async", pc, 32'h0);
    chk("reset_illegal_async", 32'(illegal), 32'h0);
    @(posedge clk);
    #1;
    chk("reset_pc_held", pc, 32'h0);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int halt_cycles;
    halt_seq[0] = 32'h0050_0093;
    halt_seq[1] = 32'h0081_2283;
    halt_seq[2] = 32'hFE51_2E23;
    halt_seq[3] = 32'h0100_00EF;
    m_pc   = 32'h0;
    m_halt = 1'b0;

    // Reset with ADDI x1,x0,5 on the bus.
    reset    = 1'b0;
    instr    = 32'h0050_0093;
    alu_zero = 1'b0;
    #2;
    chk("rst_pc", pc, 32'h0);
    chk("rst_illegal", 32'(illegal), 32'h0);
    chk("rst_addi_rw", 32'(reg_write), 32'h1);
    chk("rst_addi_src", 32'(alu_src), 32'h1);
    chk("rst_addi_imm", imm, 32'd5);
    chk("rst_addi_rd", 32'(rd), 32'd1);
    @(posedge clk);
    #1;
    chk("rst_pc_edge", pc, 32'h0);
    #6;
    reset = 1'b1;

    apply(32'h0050_0093, 1'b0);
    chk("first_pc", pc, 32'h0);
    tick();
    chk("pc_4", pc, 32'h4);
    apply(32'h0050_0093, 1'b0);
    tick();
    chk("pc_8", pc, 32'h8);

    apply(32'h4020_81B3, 1'b0);
    chk("sub_alu", 32'(alu_ctrl), 32'd1);
    chk("sub_src", 32'(alu_src), 32'd0);
    chk("sub_rw", 32'(reg_write), 32'd1);
    chk("sub_wb", 32'(wb_sel), 32'd0);
    chk("sub_rs1", 32'(rs1), 32'd1);
    chk("sub_rs2", 32'(rs2), 32'd2);
    chk("sub_rd", 32'(rd), 32'd3);
    tick();

    apply(32'h0081_2283, 1'b0);
    chk("lw_mr", 32'(mem_read), 32'd1);
    chk("lw_wb", 32'(wb_sel), 32'd1);
    chk("lw_imm", imm, 32'd8);
    tick();
    chk("pc_10", pc, 32'h10);

    apply(32'hFE20_8CE3, 1'b0);
    tick();
    chk("beq_not_taken", pc, 32'h14);

    apply(32'hFE51_2E23, 1'b0);
    chk("sw_mw", 32'(mem_write), 32'd1);
    chk("sw_rw", 32'(reg_write), 32'd0);
    chk("sw_imm", imm, 32'hFFFF_FFFC);
    tick();

    apply(32'hFE20_8CE3, 1'b1);
    tick();
    chk("back_to_10", pc, 32'h10);
    apply(32'hFE20_8CE3, 1'b1);
    tick();
    chk("beq_taken", pc, 32'h08);

    apply(enc_j(5'd0, 24), 1'b0);
    tick();
    chk("pc_20", pc, 32'h20);
    apply(32'h0100_00EF, 1'b0);
    chk("jal_wb", 32'(wb_sel), 32'd2);
    chk("jal_link", pc_plus4, 32'h24);
    tick();
    chk("jal_target", pc, 32'h30);

    apply(32'h1234_53B7, 1'b0);
    chk("lui_imm", imm, 32'h1234_5000);
    chk("lui_wb", 32'(wb_sel), 32'd3);
    tick();

    apply(enc_b(3'b001, -44), 1'b0);
    tick();
    chk("bne_taken", pc, 32'h08);

    apply(32'h0000_0000, 1'b0);
    chk("ill_rw", 32'(reg_write), 32'd0);
    chk("ill_mr", 32'(mem_read), 32'd0);
    chk("ill_mw", 32'(mem_write), 32'd0);
    chk("ill_not_yet", 32'(illegal), 32'd0);
    tick();
    chk("ill_set", 32'(illegal), 32'd1);
    chk("ill_pc", pc, 32'h08);
    for (int i = 0; i < 4; i++) begin
      apply(halt_seq[i], 1'b1);
      tick();
      chk("halt_pc", pc, 32'h08);
    end
    do_reset();
    chk("cleared", 32'(illegal), 32'd0);

    // pc wraps from 0xFFFF_FFFC to 0.
    apply(enc_j(5'd1, -4), 1'b0);
    tick();
    chk("pc_top", pc, 32'hFFFF_FFFC);
    apply(32'h0050_0093, 1'b0);
    chk("plus4_wrap", pc_plus4, 32'h0);
    tick();
    chk("pc_wrap", pc, 32'h0);

    // Reset across an edge beats a pending jump.
    apply(enc_j(5'd0, 100), 1'b0);
    do_reset();
    apply(32'h0050_0093, 1'b0);
    tick();
    chk("post_reset_fetch", pc, 32'h4);

    halt_cycles = 0;
    for (int n = 0; n < 400; n++) begin
      apply(rand_instr(), 1'($urandom_range(0, 1)));
      tick();
      if (m_halt) begin
        halt_cycles++;
        if (halt_cycles >= 2) begin
          do_reset();
          halt_cycles = 0;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Control unit of the single-cycle (monocycle) RV32I-subset processor.
- Owns the program counter and next-PC selection.
- Decodes the current instruction word combinationally into datapath control signals, register indices and sign-extended immediate.
- Sits between instruction memory (drives its address, consumes its data) and the register file / ALU / data memory.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, datapath and instruction width; only 32 is supported.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- instr  input  32  instruction word fetched at pc.
- alu_zero  input  1  ALU result-equals-zero flag for the current instruction.
- pc  output  32  current program counter, instruction-memory address.
- pc_plus4  output  32  pc + 4, used for JAL link write-back.
- rs1, rs2, rd  output  5 each  instr[19:15], instr[24:20], instr[11:7].
- imm  output  32  sign-extended immediate (I/S/B/U/J per opcode).
- alu_src  output  1  0 = rs2 data, 1 = imm as ALU operand B.
- alu_ctrl  output  4  ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLL=6, SRL=7, SRA=8.
- reg_write  output  1  register-file write enable.
- mem_read  output  1  data-memory read enable.
- mem_write  output  1  data-memory write enable.
- wb_sel  output  2  00 ALU, 01 memory, 10 pc_plus4, 11 imm.
- illegal  output  1  sticky illegal-instruction / halted flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=RESET_PC and illegal=0 immediately.
  - Decode outputs remain combinational from instr.
- Every rising edge with reset=1 and illegal=0, pc loads next_pc:
  - BEQ taken when alu_zero=1; BNE taken when alu_zero=0 → pc+immB.
  - JAL → pc+immJ.
  - otherwise → pc+4.
- All arithmetic is modulo 2^32; pc wraps from 0xFFFF_FFFC to 0.
- Decode (combinational, zero-cycle latency):
  - R-type (0110011), funct3/funct7 select: ADD, SUB (f7=0100000), AND, OR, XOR, SLT, SLL, SRL, SRA (f7=0100000). Outputs: reg_write=1, alu_src=0, wb_sel=00.
  - I-ALU (0010011): ADDI, ANDI, ORI, XORI, SLTI, SLLI, SRLI, SRAI (shamt=instr[24:20], imm[30] selects SRA). Outputs: reg_write=1, alu_src=1, wb_sel=00.
  - LW (0000011, f3=010): ADD, alu_src=1, mem_read=1, reg_write=1, wb_sel=01.
  - SW (0100011, f3=010): ADD, alu_src=1, mem_write=1, reg_write=0.
  - BEQ/BNE (1100011, f3=000/001): SUB, alu_src=0, no writes.
  - JAL (1101111): reg_write=1, wb_sel=10.
  - LUI (0110111): imm = instr[31:12]<<12, reg_write=1, wb_sel=11.
- Unlisted opcode/funct combinations, including instr=32'h0000_0000, are illegal:
  - All write/read enables are 0 in that cycle.
  - illegal is set at the next edge.
- Halt:
  - Once illegal=1, pc freezes and reg_write, mem_write and mem_read are forced to 0.
  - Only reset clears the halt.
- Default outputs for non-driving fields: alu_ctrl=ADD, alu_src=0, wb_sel=00.
- Reset asserted mid-run overrides any pending branch/jump; the first edge after release fetches RESET_PC+4 only if instr at RESET_PC is non-branching.

Test Plan:
- Reset: hold reset=0 for 10 time units, instr=ADDI x1,x0,5 (32'h0050_0093) → pc=0 during reset; after release pc=0,4,8 on successive edges; reg_write=1, alu_src=1, imm=5, rd=1.
- R-type: instr=SUB x3,x1,x2 (32'h4020_81B3) → alu_ctrl=1, alu_src=0, reg_write=1, wb_sel=00, rs1=1, rs2=2, rd=3.
- Memory: LW x5,8(x2) (32'h0081_2283) → mem_read=1, wb_sel=01, imm=8; SW x5,-4(x2) (32'hFE51_2E23) → mem_write=1, reg_write=0, imm=32'hFFFF_FFFC.
- Branch: at pc=0x10, BEQ x1,x2,-8 (32'hFE20_8CE3) with alu_zero=1 → pc=0x08 next edge; with alu_zero=0 → pc=0x14.
- Jump/LUI: at pc=0x20, JAL x1,+16 (32'h0100_00EF) → pc=0x30, wb_sel=10, pc_plus4=0x24; LUI x7,0x12345 (32'h1234_53B7) → imm=32'h1234_5000, wb_sel=11.
- Illegal: instr=32'h0000_0000 at pc=0x8 → enables 0, illegal=1 next edge, pc stays 0x8 indefinitely; reset=0 clears illegal and sets pc=0.
